// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared defaults and derived-width helpers for the multi-port register file.
// Everything that needs ADDR_W or BE_W derives it through these functions so
// the top, the interface and the merge sub-module always agree.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_NRD    = 2;
  localparam int DEF_NWR    = 2;

  // Address width for a register count that is a power of two (>= 2).
  function automatic int addr_w(input int nregs);
    return $clog2(nregs);
  endfunction

  // Number of byte lanes in a register word.
  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if
// Bundles the read ports, write ports and scoreboard controls of reg_file_mp.
//   master : pipeline side, drives addresses / write buses / scoreboard controls
//   slave  : register file side, returns read data and busy flags
// Signals (flat, port i at [i*W +: W]):
//   rd_addr NRD*ADDR_W, rd_data NRD*DATA_W, rd_busy NRD,
//   wr_be NWR*BE_W, wr_addr NWR*ADDR_W, wr_data NWR*DATA_W, wr_clr NWR,
//   sb_set 1, sb_addr ADDR_W.
// Handshake: there is none. Every input is a level that the caller holds stable
// around the rising edge; a write happens when any wr_be bit is set, a busy
// clear when wr_clr is set, a busy set when sb_set is set. Reads are pure
// combinational functions of the current inputs and stored state.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR
);
  localparam int ADDR_W = addr_w(NREGS);
  localparam int BE_W   = be_w(DATA_W);

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR*BE_W-1:0]   wr_be;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic [NWR-1:0]        wr_clr;
  logic                  sb_set;
  logic [ADDR_W-1:0]     sb_addr;

  modport master (
    output rd_addr, wr_be, wr_addr, wr_data, wr_clr, sb_set, sb_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_be, wr_addr, wr_data, wr_clr, sb_set, sb_addr,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/reg_file_wmerge.sv
// reg_file_wmerge
// Byte-wise merge of the NWR write buses onto a base word for one address.
// Each byte lane takes the data of the highest-index port whose address
// matches and whose byte enable is set; lanes nobody writes keep the base.
// Used both as the next-state logic of every stored register and as the
// same-cycle bypass of every read port, so both see identical priority.
// Ports:
//   base_i    DATA_W        word before this cycle's writes
//   addr_i    ADDR_W        register this merge is evaluated for
//   wr_be_i   NWR*BE_W      per-port byte enables
//   wr_addr_i NWR*ADDR_W    per-port write addresses
//   wr_data_i NWR*DATA_W    per-port write data
//   merged_o  DATA_W        merged word
module reg_file_wmerge
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int NWR    = DEF_NWR
) (
  input  logic [DATA_W-1:0]                 base_i,
  input  logic [addr_w(NREGS)-1:0]          addr_i,
  input  logic [NWR*be_w(DATA_W)-1:0]       wr_be_i,
  input  logic [NWR*addr_w(NREGS)-1:0]      wr_addr_i,
  input  logic [NWR*DATA_W-1:0]             wr_data_i,
  output logic [DATA_W-1:0]                 merged_o
);
  localparam int ADDR_W = addr_w(NREGS);
  localparam int BE_W   = be_w(DATA_W);

  // Ascending port order: a later (higher) port overwrites an earlier one.
  always_comb begin
    merged_o = base_i;
    for (int p = 0; p < NWR; p++) begin
      if (wr_addr_i[p*ADDR_W +: ADDR_W] == addr_i) begin
        for (int b = 0; b < BE_W; b++) begin
          if (wr_be_i[p*BE_W + b]) begin
            merged_o[b*8 +: 8] = wr_data_i[p*DATA_W + b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp
// Multi-port integer register file with per-byte writes, optional same-cycle
// write-to-read bypass and a per-register busy scoreboard. Register 0 reads
// as zero and is never busy; it has no storage.
// Ports:
//   clk     single clock, rising edge
//   resetn  asynchronous active-low reset; while low all reads return 0/0
//   bus     reg_file_mp_if.slave (read ports, write ports, scoreboard)
// Parameters: DATA_W, NREGS, NRD, NWR (higher port index wins), BYPASS.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR,
  parameter bit BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         resetn,
  reg_file_mp_if.slave bus
);
  localparam int ADDR_W = addr_w(NREGS);

  // Register storage (index 0 intentionally absent).
  logic [DATA_W-1:0] regs_q [1:NREGS-1];
  logic [DATA_W-1:0] regs_d [1:NREGS-1];

  // Full-range view with register 0 tied to zero, for read indexing.
  logic [DATA_W-1:0] rf_view [NREGS];

  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  // ---------------------------------------------------------------------------
  // Write path: one merge per stored register.
  // ---------------------------------------------------------------------------
  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    reg_file_wmerge #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .NWR    (NWR)
    ) u_wmerge (
      .base_i    (regs_q[r]),
      .addr_i    (ADDR_W'(r)),
      .wr_be_i   (bus.wr_be),
      .wr_addr_i (bus.wr_addr),
      .wr_data_i (bus.wr_data),
      .merged_o  (regs_d[r])
    );

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        regs_q[r] <= '0;
      end else begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  always_comb begin
    rf_view[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      rf_view[r] = regs_q[r];
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard. Clears are applied first so that a set to the same
  // register in the same cycle (a new producer issuing) wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      for (int p = 0; p < NWR; p++) begin
        if (bus.wr_clr[p] && (bus.wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          busy_d[r] = 1'b0;
        end
      end
      if (bus.sb_set && (bus.sb_addr == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports. With bypass the read sees the next-state word and busy bit;
  // both are forced to zero during reset so in-flight writes are not visible.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] stored;

    assign ra     = bus.rd_addr[i*ADDR_W +: ADDR_W];
    assign stored = rf_view[ra];

    if (BYPASS) begin : g_byp
      logic [DATA_W-1:0] merged;

      reg_file_wmerge #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .NWR    (NWR)
      ) u_bypass (
        .base_i    (stored),
        .addr_i    (ra),
        .wr_be_i   (bus.wr_be),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .merged_o  (merged)
      );

      assign bus.rd_data[i*DATA_W +: DATA_W] = (resetn && (ra != '0)) ? merged : '0;
      assign bus.rd_busy[i]                  = resetn && busy_d[ra];
    end else begin : g_nobyp
      assign bus.rd_data[i*DATA_W +: DATA_W] = resetn ? stored : '0;
      assign bus.rd_busy[i]                  = resetn && busy_q[ra];
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp
// Drives a bypassing and a non-bypassing instance of reg_file_mp with the same
// stimulus and checks both against constant vectors and a reference model.
module tb_reg_file_mp;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(DW), .NREGS(NR), .NRD(2), .NWR(2)) bus_b ();
  reg_file_mp_if #(.DATA_W(DW), .NREGS(NR), .NRD(2), .NWR(2)) bus_n ();

  reg_file_mp #(.DATA_W(DW), .NREGS(NR), .NRD(2), .NWR(2), .BYPASS(1'b1)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_b)
  );

  reg_file_mp #(.DATA_W(DW), .NREGS(NR), .NRD(2), .NWR(2), .BYPASS(1'b0)) dut_n (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_n)
  );

  typedef struct packed {
    logic [2*AW-1:0] rd_addr;
    logic [7:0]      wr_be;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic [1:0]      wr_clr;
    logic            sb_set;
    logic [AW-1:0]   sb_addr;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic [31:0] exp_bd;  // bypass instance, read port 0 data
    logic [31:0] exp_nd;  // non-bypass instance, read port 0 data
    logic        exp_bb;  // bypass instance, read port 0 busy
    logic        exp_nb;  // non-bypass instance, read port 0 busy
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];

  // Reference state: what each architectural register and busy flag holds.
  logic [31:0] m_mem  [NR];
  logic        m_busy [NR];

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input stim_t s);
    bus_b.rd_addr = s.rd_addr;  bus_n.rd_addr = s.rd_addr;
    bus_b.wr_be   = s.wr_be;    bus_n.wr_be   = s.wr_be;
    bus_b.wr_addr = s.wr_addr;  bus_n.wr_addr = s.wr_addr;
    bus_b.wr_data = s.wr_data;  bus_n.wr_data = s.wr_data;
    bus_b.wr_clr  = s.wr_clr;   bus_n.wr_clr  = s.wr_clr;
    bus_b.sb_set  = s.sb_set;   bus_n.sb_set  = s.sb_set;
    bus_b.sb_addr = s.sb_addr;  bus_n.sb_addr = s.sb_addr;
  endtask

  function automatic stim_t mk(input logic [4:0] ra0,
                               input logic [3:0] be0, input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [3:0] be1, input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic [1:0] clr, input logic set, input logic [4:0] sa);
    stim_t s;
    s.rd_addr = {5'd1, ra0};
    s.wr_be   = {be1, be0};
    s.wr_addr = {wa1, wa0};
    s.wr_data = {wd1, wd0};
    s.wr_clr  = clr;
    s.sb_set  = set;
    s.sb_addr = sa;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] word_after(input logic [31:0] base, input int r, input stim_t s);
    logic [31:0] w;
    w = base;
    for (int p = 0; p < 2; p++) begin
      if (int'(s.wr_addr[p*AW +: AW]) == r) begin
        for (int b = 0; b < 4; b++) begin
          if (s.wr_be[p*4 + b]) w[b*8 +: 8] = s.wr_data[p*DW + b*8 +: 8];
        end
      end
    end
    return (r == 0) ? 32'h0 : w;
  endfunction

  function automatic logic busy_after(input int r, input stim_t s);
    logic b;
    b = m_busy[r];
    for (int p = 0; p < 2; p++) begin
      if (s.wr_clr[p] && int'(s.wr_addr[p*AW +: AW]) == r) b = 1'b0;
    end
    if (s.sb_set && int'(s.sb_addr) == r) b = 1'b1;
    return (r == 0) ? 1'b0 : b;
  endfunction

  task automatic model_commit(input stim_t s);
    logic [31:0] nm [NR];
    logic        nb [NR];
    for (int r = 0; r < NR; r++) begin
      nm[r] = word_after(m_mem[r], r, s);
      nb[r] = busy_after(r, s);
    end
    for (int r = 0; r < NR; r++) begin
      m_mem[r]  = nm[r];
      m_busy[r] = nb[r];
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bd"}, bus_b.rd_data[31:0], 32'h0);
    check({tag, "_nd"}, bus_n.rd_data[31:0], 32'h0);
    check({tag, "_bb"}, {31'b0, bus_b.rd_busy[0]}, 32'h0);
    check({tag, "_nb"}, {31'b0, bus_n.rd_busy[0]}, 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  vec_t vecs [14];
  stim_t s;

  initial begin
    model_reset();

    vecs[0]  = '{mk(3, 4'hF, 3, 32'h11223344, 4'h5, 3, 32'hAABBCCDD, 2'b00, 1'b0, 0), 32'h11BB33DD, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{mk(3, 4'h0, 0, 32'h0, 4'h0, 0, 32'h0, 2'b00, 1'b0, 0), 32'h11BB33DD, 32'h11BB33DD, 1'b0, 1'b0};
    vecs[2]  = '{mk(7, 4'hF, 7, 32'h12345678, 4'h0, 0, 32'h0, 2'b00, 1'b0, 0), 32'h12345678, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{mk(7, 4'h0, 0, 32'h0, 4'h0, 0, 32'h0, 2'b00, 1'b0, 0), 32'h12345678, 32'h12345678, 1'b0, 1'b0};
    vecs[4]  = '{mk(0, 4'hF, 0, 32'hFFFFFFFF, 4'hF, 0, 32'hFFFFFFFF, 2'b00, 1'b1, 0), 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[5]  = '{mk(0, 4'h0, 0, 32'h0, 4'h0, 0, 32'h0, 2'b00, 1'b0, 0), 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[6]  = '{mk(9, 4'h0, 0, 32'h0, 4'h0, 0, 32'h0, 2'b00, 1'b1, 9), 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[7]  = '{mk(9, 4'h0, 0, 32'h0, 4'h0, 0, 32'h0, 2'b00, 1'b0, 0), 32'h0, 32'h0, 1'b1, 1'b1};
    vecs[8]  = '{mk(9, 4'h0, 0, 32'h0, 4'h0, 9, 32'h0, 2'b10, 1'b1, 9), 32'h0, 32'h0, 1'b1, 1'b1};
    vecs[9]  = '{mk(9, 4'h0, 0, 32'h0, 4'h0, 0, 32'h0, 2'b00, 1'b0, 0), 32'h0, 32'h0, 1'b1, 1'b1};
    vecs[10] = '{mk(9, 4'h0, 0, 32'h0, 4'h0, 9, 32'h0, 2'b10, 1'b0, 0), 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[11] = '{mk(9, 4'h0, 0, 32'h0, 4'h0, 0, 32'h0, 2'b00, 1'b0, 0), 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[12] = '{mk(3, 4'h1, 3, 32'h000000EE, 4'h8, 3, 32'h77000000, 2'b00, 1'b0, 0), 32'h77BB33EE, 32'h11BB33DD, 1'b0, 1'b0};
    vecs[13] = '{mk(3, 4'h0, 0, 32'h0, 4'h0, 0, 32'h0, 2'b00, 1'b0, 0), 32'h77BB33EE, 32'h77BB33EE, 1'b0, 1'b0};

    // Reset held with an aggressive write and set pending: nothing visible.
    resetn = 1'b0;
    drive(mk(5, 4'hF, 5, 32'hDEADBEEF, 4'hF, 5, 32'hDEADBEEF, 2'b00, 1'b1, 5));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_zero($sformatf("rst_hold%0d", c));
      @(posedge clk);
      #1;
    end
    drive(mk(5, 4'h0, 0, 32'h0, 4'h0, 0, 32'h0, 2'b00, 1'b0, 0));
    #1 resetn = 1'b1;
    @(negedge clk);
    check_zero("rst_after");
    @(posedge clk);
    #1;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].s);
      @(negedge clk);
      check($sformatf("vec%0d_bd", i), bus_b.rd_data[31:0], vecs[i].exp_bd);
      check($sformatf("vec%0d_nd", i), bus_n.rd_data[31:0], vecs[i].exp_nd);
      check($sformatf("vec%0d_bb", i), {31'b0, bus_b.rd_busy[0]}, {31'b0, vecs[i].exp_bb});
      check($sformatf("vec%0d_nb", i), {31'b0, bus_n.rd_busy[0]}, {31'b0, vecs[i].exp_nb});
      model_commit(vecs[i].s);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset between edges while r4 is busy and a write is pending.
    s = mk(4, 4'hF, 4, 32'h55AA55AA, 4'h0, 0, 32'h0, 2'b00, 1'b1, 4);
    drive(s);
    @(negedge clk);
    model_commit(s);
    @(posedge clk);
    #1;
    drive(mk(4, 4'hF, 4, 32'hCAFEF00D, 4'h0, 0, 32'h0, 2'b00, 1'b0, 0));
    @(negedge clk);
    check("arst_pre_bd", bus_b.rd_data[31:0], 32'hCAFEF00D);
    check("arst_pre_nd", bus_n.rd_data[31:0], 32'h55AA55AA);
    check("arst_pre_bb", {31'b0, bus_b.rd_busy[0]}, 32'h1);
    check("arst_pre_nb", {31'b0, bus_n.rd_busy[0]}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    check_zero("arst_drop");
    model_reset();
    drive(mk(4, 4'h0, 0, 32'h0, 4'h0, 0, 32'h0, 2'b00, 1'b0, 0));
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check_zero("arst_after");
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model, with address collisions.
    for (int c = 0; c < 300; c++) begin
      s.rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      s.wr_be   = 8'($urandom);
      s.wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      s.wr_data = {$urandom, $urandom};
      s.wr_clr  = 2'($urandom);
      s.sb_set  = 1'($urandom);
      s.sb_addr = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      if (c % 5 == 0) s.wr_be = '0;
      drive(s);
      for (int i = 0; i < 2; i++) begin
        int a;
        a = int'(s.rd_addr[i*AW +: AW]);
        exp_q.push_back(word_after(m_mem[a], a, s));
        exp_q.push_back({31'b0, busy_after(a, s)});
        exp_q.push_back(m_mem[a]);
        exp_q.push_back({31'b0, m_busy[a]});
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("rnd%0d_bd%0d", c, i), bus_b.rd_data[i*DW +: DW], exp_q.pop_front());
        check($sformatf("rnd%0d_bb%0d", c, i), {31'b0, bus_b.rd_busy[i]}, exp_q.pop_front());
        check($sformatf("rnd%0d_nd%0d", c, i), bus_n.rd_data[i*DW +: DW], exp_q.pop_front());
        check($sformatf("rnd%0d_nb%0d", c, i), {31'b0, bus_n.rd_busy[i]}, exp_q.pop_front());
      end
      model_commit(s);
      @(posedge clk);
      #1;
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
